// File: rtl/clk_mgr_pkg.sv
// rtl/clk_mgr_pkg.sv - shared state encoding and limits for the mic clock manager
package clk_mgr_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_IDLE      = 2'd1,
    ST_RUN       = 2'd2,
    ST_DRAIN     = 2'd3
  } state_t;

  localparam int MIN_DIV = 2;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a single asynchronous level
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/mic_clk_gen.sv
// rtl/mic_clk_gen.sv - mic bit clock / word select / lock-qualified mic reset generator
module mic_clk_gen
  import clk_mgr_pkg::*;
#(
  parameter int DIV_W       = 8,
  parameter int DIV_DEFAULT = 30,
  parameter int FRAME_BITS  = 64,
  parameter int LOCK_WAIT   = 1024
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             pll_lock,
  input  logic             en,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_load,
  output logic             sck,
  output logic             sck_rise,
  output logic             sck_fall,
  output logic             ws,
  output logic             frame_start,
  output logic             rst_mic_n,
  output logic             cfg_pend,
  output logic             running
);

  localparam int BCW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam int LCW = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;

  logic             lock_s;
  state_t           state, state_nxt;
  logic [LCW-1:0]   lock_cnt;
  logic [DIV_W-1:0] cur_div, pend_div, eff_div, half, hc;
  logic [BCW-1:0]   bc, bc_inc;
  logic             active, half_done, fall_now, boundary, apply_now;
  logic             rst_mic_n_d, running_d;

  sync_2ff u_lock_sync (
    .clk   (clk_in),
    .rst_n (rst_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

  // Even period, never below MIN_DIV, so high and low phases are always equal.
  always_comb begin
    eff_div    = (cur_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : cur_div;
    eff_div[0] = 1'b0;
    half       = eff_div >> 1;
  end

  assign active    = (state == ST_RUN) || (state == ST_DRAIN);
  assign half_done = active && (hc == half - DIV_W'(1));
  assign fall_now  = half_done && sck;
  assign boundary  = fall_now && (bc == BCW'(FRAME_BITS - 1));
  assign bc_inc    = bc + BCW'(1);
  assign apply_now = cfg_pend && (active ? boundary : 1'b1);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) state <= ST_WAIT_LOCK;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!lock_s) begin
      state_nxt = ST_WAIT_LOCK;
    end else begin
      case (state)
        ST_WAIT_LOCK: if (lock_cnt == LCW'(LOCK_WAIT - 1)) state_nxt = ST_IDLE;
        ST_IDLE:      if (en) state_nxt = ST_RUN;
        ST_RUN:       if (!en) state_nxt = ST_DRAIN;
        ST_DRAIN: begin
          if (en)            state_nxt = ST_RUN;
          else if (boundary) state_nxt = ST_IDLE;
        end
        default:      state_nxt = ST_WAIT_LOCK;
      endcase
    end
  end

  always_comb begin
    rst_mic_n_d = (state_nxt != ST_WAIT_LOCK);
    running_d   = (state_nxt == ST_RUN) || (state_nxt == ST_DRAIN);
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      rst_mic_n   <= 1'b0;
      running     <= 1'b0;
      lock_cnt    <= '0;
      hc          <= '0;
      bc          <= '0;
      sck         <= 1'b0;
      ws          <= 1'b0;
      sck_rise    <= 1'b0;
      sck_fall    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      rst_mic_n   <= rst_mic_n_d;
      running     <= running_d;
      sck_rise    <= 1'b0;
      sck_fall    <= 1'b0;
      frame_start <= 1'b0;

      if (state == ST_WAIT_LOCK && lock_s) lock_cnt <= lock_cnt + LCW'(1);
      else                                 lock_cnt <= '0;

      if (!lock_s) begin
        hc  <= '0;
        bc  <= '0;
        sck <= 1'b0;
        ws  <= 1'b0;
      end else if (state == ST_IDLE && en) begin
        hc          <= '0;
        bc          <= '0;
        sck         <= 1'b0;
        ws          <= 1'b0;
        frame_start <= 1'b1;
      end else if (active) begin
        if (half_done) begin
          hc       <= '0;
          sck      <= ~sck;
          sck_rise <= ~sck;
          sck_fall <= sck;
          if (fall_now) begin
            bc          <= boundary ? '0 : bc_inc;
            ws          <= boundary ? 1'b0 : (bc_inc >= BCW'(FRAME_BITS / 2));
            // A drain that is not cancelled ends the frame silently.
            frame_start <= boundary && !(state == ST_DRAIN && !en);
          end
        end else begin
          hc <= hc + DIV_W'(1);
        end
      end else begin
        hc  <= '0;
        bc  <= '0;
        sck <= 1'b0;
        ws  <= 1'b0;
      end
    end
  end

  // A load in the boundary cycle itself stays pending for the following frame.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cur_div  <= DIV_W'(DIV_DEFAULT);
      pend_div <= DIV_W'(DIV_DEFAULT);
      cfg_pend <= 1'b0;
    end else begin
      if (apply_now) cur_div <= pend_div;
      if (cfg_load) begin
        pend_div <= cfg_div;
        cfg_pend <= 1'b1;
      end else if (apply_now) begin
        cfg_pend <= 1'b0;
      end
    end
  end

endmodule
